// File: rtl/rv_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for rv_decode_stage.
// The master side is the environment (fetch + consumer); the slave side is the stage.
interface rv_decode_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rs1_en;
  logic            out_rs2_en;
  logic            out_rd_we;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
    input  out_rs1, out_rs2, out_rd, out_rs1_en, out_rs2_en, out_rd_we,
    input  out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
    output out_rs1, out_rs2, out_rd, out_rs1_en, out_rs2_en, out_rd_we,
    output out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage: combinational decode of the offered word into an output
// register, with an optional skid register so back-pressure does not cost throughput.
module rv_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32,
  parameter int unsigned SKID = 1
) (
  input logic            clk,
  input logic            rst,
  rv_decode_stage_if.slave bus
);

  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtI   = 3'd1;
  localparam logic [2:0] FmtS   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtU   = 3'd4;
  localparam logic [2:0] FmtJ   = 3'd5;
  localparam logic [2:0] FmtIll = 3'd7;

  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [6:0] F7Alt = 7'b0100000;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rs1_en;
    logic            rs2_en;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;

  assign instr = bus.in_instr;
  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign rs1_f = instr[19:15];
  assign rs2_f = instr[24:20];
  assign rd_f  = instr[11:7];

  entry_t      dec;
  logic        legal;
  logic        no_side;
  logic [2:0]  fmt_sel;
  logic [31:0] imm32;

  // Decode the offered word; an illegal word keeps only its PC and opcode.
  always_comb begin
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.opcode = op;
    dec.fmt    = FmtIll;
    dec.illegal = 1'b1;
    legal      = 1'b0;
    no_side    = 1'b0;
    fmt_sel    = FmtIll;
    imm32      = '0;

    case (op)
      OpOp: begin
        fmt_sel = FmtR;
        legal   = (f7 == 7'd0) || ((f7 == F7Alt) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OpImm: begin
        fmt_sel = FmtI;
        legal   = !(((f3 == 3'b001) && (f7 != 7'd0)) ||
                    ((f3 == 3'b101) && (f7 != 7'd0) && (f7 != F7Alt)));
      end
      OpLoad: begin
        fmt_sel = FmtI;
        legal   = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
      end
      OpJalr: begin
        fmt_sel = FmtI;
        legal   = (f3 == 3'b000);
      end
      OpSystem, OpFence: begin
        fmt_sel = FmtI;
        legal   = 1'b1;
        no_side = 1'b1;
      end
      OpStore: begin
        fmt_sel = FmtS;
        legal   = (f3 < 3'b011);
      end
      OpBranch: begin
        fmt_sel = FmtB;
        legal   = !((f3 == 3'b010) || (f3 == 3'b011));
      end
      OpLui, OpAuipc: begin
        fmt_sel = FmtU;
        legal   = 1'b1;
      end
      OpJal: begin
        fmt_sel = FmtJ;
        legal   = 1'b1;
      end
      default: begin
        fmt_sel = FmtIll;
        legal   = 1'b0;
      end
    endcase

    if (instr[1:0] != 2'b11) begin
      legal = 1'b0;
    end

    if (legal) begin
      dec.fmt     = fmt_sel;
      dec.illegal = 1'b0;
      case (fmt_sel)
        FmtR: begin
          dec.func3  = f3;
          dec.func7  = f7;
          dec.rs1    = rs1_f;
          dec.rs2    = rs2_f;
          dec.rd     = rd_f;
          dec.rs1_en = 1'b1;
          dec.rs2_en = 1'b1;
          dec.rd_we  = (rd_f != 5'd0);
        end
        FmtI: begin
          dec.func3  = f3;
          dec.rs1    = rs1_f;
          dec.rd     = rd_f;
          dec.rs1_en = !no_side;
          dec.rd_we  = !no_side && (rd_f != 5'd0);
          imm32      = {{20{instr[31]}}, instr[31:20]};
        end
        FmtS: begin
          dec.func3  = f3;
          dec.rs1    = rs1_f;
          dec.rs2    = rs2_f;
          dec.rs1_en = 1'b1;
          dec.rs2_en = 1'b1;
          imm32      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end
        FmtB: begin
          dec.func3  = f3;
          dec.rs1    = rs1_f;
          dec.rs2    = rs2_f;
          dec.rs1_en = 1'b1;
          dec.rs2_en = 1'b1;
          imm32      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        FmtU: begin
          dec.rd    = rd_f;
          dec.rd_we = (rd_f != 5'd0);
          imm32     = {instr[31:12], 12'b0};
        end
        FmtJ: begin
          dec.rd    = rd_f;
          dec.rd_we = (rd_f != 5'd0);
          imm32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        default: begin
          imm32 = '0;
        end
      endcase
      dec.imm = XLEN'($signed(imm32));
    end
  end

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   in_ready;
  logic   accept;

  // in_ready_q doubles as the "out of reset" flag for the combinational SKID=0 ready.
  assign in_ready = (SKID != 0) ? in_ready_q
                                : (in_ready_q && (!out_valid_q || bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_valid_q && !bus.out_ready) begin
      if (accept && (SKID != 0)) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      // Skid is full here, so in_ready is low and nothing new is accepted this cycle.
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = 1'b0;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_opcode  = out_q.opcode;
  assign bus.out_func3   = out_q.func3;
  assign bus.out_func7   = out_q.func7;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1_en  = out_q.rs1_en;
  assign bus.out_rs2_en  = out_q.rs2_en;
  assign bus.out_rd_we   = out_q.rd_we;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Drives three stage instances (SKID=1, SKID=0, XLEN=64) from one stimulus stream and checks
// each against an occupancy model holding entries decoded arithmetically from the ISA rules.
module tb_rv_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_we;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } dec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  rv_decode_stage_if #(.XLEN(32), .PC_W(32)) if0 ();
  rv_decode_stage_if #(.XLEN(32), .PC_W(32)) if1 ();
  rv_decode_stage_if #(.XLEN(64), .PC_W(32)) if2 ();

  rv_decode_stage #(.XLEN(32), .PC_W(32), .SKID(1)) u_skid (.clk(clk), .rst(rst), .bus(if0));
  rv_decode_stage #(.XLEN(32), .PC_W(32), .SKID(0)) u_noskid (.clk(clk), .rst(rst), .bus(if1));
  rv_decode_stage #(.XLEN(64), .PC_W(32), .SKID(1)) u_wide (.clk(clk), .rst(rst), .bus(if2));

  assign if0.flush = flush;     assign if1.flush = flush;     assign if2.flush = flush;
  assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
  assign if0.in_instr = in_instr; assign if1.in_instr = in_instr; assign if2.in_instr = in_instr;
  assign if0.in_pc = in_pc;     assign if1.in_pc = in_pc;     assign if2.in_pc = in_pc;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready;
  assign if2.out_ready = out_ready;

  dec_t obs [3];
  logic obs_valid [3];
  logic obs_ready [3];

  assign obs[0] = {if0.out_pc, if0.out_opcode, if0.out_func3, if0.out_func7, if0.out_rs1,
                   if0.out_rs2, if0.out_rd, if0.out_rs1_en, if0.out_rs2_en, if0.out_rd_we,
                   32'd0, if0.out_imm, if0.out_fmt, if0.out_illegal};
  assign obs[1] = {if1.out_pc, if1.out_opcode, if1.out_func3, if1.out_func7, if1.out_rs1,
                   if1.out_rs2, if1.out_rd, if1.out_rs1_en, if1.out_rs2_en, if1.out_rd_we,
                   32'd0, if1.out_imm, if1.out_fmt, if1.out_illegal};
  assign obs[2] = {if2.out_pc, if2.out_opcode, if2.out_func3, if2.out_func7, if2.out_rs1,
                   if2.out_rs2, if2.out_rd, if2.out_rs1_en, if2.out_rs2_en, if2.out_rd_we,
                   if2.out_imm, if2.out_fmt, if2.out_illegal};
  assign obs_valid[0] = if0.out_valid; assign obs_valid[1] = if1.out_valid;
  assign obs_valid[2] = if2.out_valid;
  assign obs_ready[0] = if0.in_ready;  assign obs_ready[1] = if1.in_ready;
  assign obs_ready[2] = if2.in_ready;

  int vectors = 0;
  int fails = 0;

  // Model: entries held per instance, oldest first.
  dec_t m_ent [3][2];
  int   m_cnt [3];
  bit   m_alive;
  bit   acc0;
  logic [31:0] dq [$];

  task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
    vectors++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic dec_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
    dec_t d;
    int f;
    bit ok, side, h1, h2, hd;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    longint si, imm;
    d = '0;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    si = longint'($signed(i));
    d.pc = pc;
    d.opcode = op;
    d.fmt = 3'd7;
    d.illegal = 1'b1;
    f = 7;
    ok = 1'b1;
    side = 1'b0;
    case (op)
      7'h33: begin f = 0; ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
      7'h13: begin f = 1; ok = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20); end
      7'h03: begin f = 1; ok = !(f3 inside {3'd3, 3'd6, 3'd7}); end
      7'h67: begin f = 1; ok = (f3 == 0); end
      7'h73, 7'h0f: begin f = 1; side = 1'b1; end
      7'h23: begin f = 2; ok = (f3 < 3); end
      7'h63: begin f = 3; ok = !(f3 inside {3'd2, 3'd3}); end
      7'h37, 7'h17: f = 4;
      7'h6f: f = 5;
      default: ok = 1'b0;
    endcase
    if (i[1:0] != 2'b11) ok = 1'b0;
    if (!ok) return d;
    case (f)
      1: imm = si >>> 20;
      2: imm = (si >>> 25) * 32 + longint'(i[11:7]);
      3: imm = (si >>> 31) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
               + longint'(i[11:8]) * 2;
      4: imm = (si >>> 12) * 4096;
      5: imm = (si >>> 31) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
               + longint'(i[30:21]) * 2;
      default: imm = 0;
    endcase
    h1 = (f <= 3);
    h2 = (f == 0) || (f == 2) || (f == 3);
    hd = (f == 0) || (f == 1) || (f == 4) || (f == 5);
    d.fmt = 3'(f);
    d.illegal = 1'b0;
    d.imm = imm;
    d.func3 = (f <= 3) ? f3 : 3'd0;
    d.func7 = (f == 0) ? f7 : 7'd0;
    d.rs1 = h1 ? i[19:15] : 5'd0;
    d.rs2 = h2 ? i[24:20] : 5'd0;
    d.rd = hd ? i[11:7] : 5'd0;
    d.rs1_en = h1 && !side;
    d.rs2_en = h2;
    d.rd_we = hd && !side && (i[11:7] != 0);
    return d;
  endfunction

  function automatic bit exp_ready(input int k);
    if (k != 1) return m_alive && (m_cnt[k] < 2);
    return m_alive && (m_cnt[k] == 0 || out_ready);
  endfunction

  task automatic model_check();
    dec_t e;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("in_ready[%0d]", k), 160'(obs_ready[k]), 160'(exp_ready(k)));
      chk($sformatf("out_valid[%0d]", k), 160'(obs_valid[k]), 160'(m_cnt[k] > 0));
      if (m_cnt[k] > 0) begin
        e = m_ent[k][0];
        if (k != 2) e.imm[63:32] = '0;
        chk($sformatf("entry[%0d]", k), 160'(obs[k]), 160'(e));
      end
    end
  endtask

  task automatic model_step();
    bit acc, xfer;
    acc0 = in_valid && obs_ready[0];
    if (!rst && !flush && obs_valid[0] && out_ready) dq.push_back(obs[0].pc);
    if (rst) begin
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
      m_alive = 1'b0;
    end else if (flush) begin
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
      m_alive = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        acc = in_valid && exp_ready(k);
        xfer = (m_cnt[k] > 0) && out_ready;
        if (xfer) begin
          m_ent[k][0] = m_ent[k][1];
          m_cnt[k]--;
        end
        if (acc) begin
          m_ent[k][m_cnt[k]] = ref_dec(in_instr, in_pc);
          m_cnt[k]++;
        end
      end
      m_alive = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid0", 160'(if0.out_valid), 160'(0));
    chk("rst_valid1", 160'(if1.out_valid), 160'(0));
    chk("rst_valid2", 160'(if2.out_valid), 160'(0));
    chk("rst_ready0", 160'(if0.in_ready), 160'(0));
    chk("rst_imm0", 160'(if0.out_imm), 160'(0));
    chk("rst_pc0", 160'(if0.out_pc), 160'(0));
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_alive = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12];
    logic [31:0] w;
    int sel;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0f, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h2b};
    w = $urandom;
    sel = $urandom_range(0, 13);
    if (sel < 12) w[6:0] = ops[sel];
    if (sel != 13 && $urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  logic [31:0] d_instr [5] = '{32'hFFF00093, 32'h0020A423, 32'hFE208EE3, 32'h123452B7,
                               32'h001000EF};
  logic [2:0]  d_fmt   [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [31:0] d_imm   [5] = '{32'hFFFFFFFF, 32'h8, 32'hFFFFFFFC, 32'h12345000, 32'h800};
  logic        d_we    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] i_instr [3] = '{32'h00000000, 32'h4000C0B3, 32'h0000B083};

  initial begin
    int idx, c;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_alive = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed decode stream at one instruction per cycle.
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1; in_instr = d_instr[n]; in_pc = 32'h40 + 32'(n * 4);
      cycle();
      if (n == 0) cycle();  // first clock after reset release only raises in_ready
      chk($sformatf("dir_fmt%0d", n), 160'(if0.out_fmt), 160'(d_fmt[n]));
      chk($sformatf("dir_imm%0d", n), 160'(if0.out_imm), 160'(d_imm[n]));
      chk($sformatf("dir_we%0d", n), 160'(if0.out_rd_we), 160'(d_we[n]));
    end

    for (int n = 0; n < 3; n++) begin
      in_instr = i_instr[n]; in_pc = 32'h80 + 32'(n * 4);
      cycle();
      chk($sformatf("ill_fmt%0d", n), 160'(if0.out_fmt), 160'(7));
      chk($sformatf("ill_flag%0d", n), 160'(if0.out_illegal), 160'(1));
      chk($sformatf("ill_en%0d", n), 160'({if0.out_rs1_en, if0.out_rs2_en, if0.out_rd_we}),
          160'(0));
      chk($sformatf("ill_pc%0d", n), 160'(if0.out_pc), 160'(32'h80 + 32'(n * 4)));
    end

    // Reset while an entry is valid, then first accept after release.
    chk("pre_rst_valid", 160'(if0.out_valid), 160'(1));
    in_valid = 1'b0;
    do_reset();
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100;
    cycle();
    chk("rel_ready", 160'(if0.in_ready), 160'(1));
    cycle();
    chk("rel_valid", 160'(if0.out_valid), 160'(1));
    chk("rel_pc", 160'(if0.out_pc), 160'(32'h100));
    in_valid = 1'b0;
    repeat (2) cycle();

    // Back-pressure for three cycles during a stream of six.
    dq.delete();
    idx = 0; c = 0;
    while (idx < 6 && c < 40) begin
      in_valid = 1'b1; in_instr = 32'h00000093 | (32'(idx) << 20); in_pc = 32'h200 + 32'(idx * 4);
      out_ready = !(c >= 1 && c <= 3);
      cycle();
      if (acc0) idx++;
      if (c >= 1 && c <= 3) chk($sformatf("stall_ready%0d", c), 160'(if0.in_ready), 160'(0));
      if (c == 4) chk("unstall_ready", 160'(if0.in_ready), 160'(1));
      c++;
    end
    chk("stall_cycles", 160'(c), 160'(9));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("deliv_count", 160'(dq.size()), 160'(6));
    for (int n = 0; n < 6 && n < dq.size(); n++)
      chk($sformatf("deliv_pc%0d", n), 160'(dq[n]), 160'(32'h200 + 32'(n * 4)));

    // Flush with output valid, skid full and a new word offered.
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100093; in_pc = 32'h300; cycle();
    in_instr = 32'h00200093; in_pc = 32'h304; cycle();
    chk("pre_flush_full", 160'(if0.in_ready), 160'(0));
    in_instr = 32'h00300093; in_pc = 32'h308; flush = 1'b1; cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 160'(if0.out_valid), 160'(0));
    chk("flush_ready", 160'(if0.in_ready), 160'(1));
    out_ready = 1'b1;
    dq.delete();
    repeat (3) cycle();
    chk("flush_nothing", 160'(dq.size()), 160'(0));

    // 64-bit immediates.
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h400; cycle();
    chk("w64_addi", 160'(if2.out_imm), 160'(64'hFFFFFFFFFFFFFFFF));
    in_instr = 32'h800002B7; in_pc = 32'h404; cycle();
    chk("w64_lui", 160'(if2.out_imm), 160'(64'hFFFFFFFF80000000));

    // Random traffic with back-pressure and occasional flush.
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      in_instr = rand_instr();
      in_pc = 32'h1000 + 32'(n * 4);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
